// File: rtl/mov_avr_pkg.sv
// Shared types and helpers for the mov_avr_sched time-multiplexed moving-average block.
package mov_avr_pkg;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // History RAM address is {channel, write pointer}.
  function automatic int hist_aw(input int nch, input int width);
    return $clog2(nch) + $clog2(width);
  endfunction
endpackage

// File: rtl/mov_avr_hist_ram.sv
// Simple dual-port sample history store: synchronous write, 1-cycle registered read.
// Read data holds while rd_en_i is low; a same-address read and write returns the old word.
module mov_avr_hist_ram
  import mov_avr_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  sample_t       wr_dat_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output sample_t       rd_dat_o
);
  sample_t mem_q [2**AW];
  sample_t rd_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
    if (rd_en_i) begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_q;
endmodule

// File: rtl/mov_avr_sched.sv
// Round-robin shares one moving-average datapath across NCH streams; grant to out_valid is 2 enabled cycles,
// clk_en low freezes all stages. Define MOV_AVR_SCHED_PRIO0_EN to give channel 0 strict priority.
module mov_avr_sched
  import mov_avr_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int WIDTH   = 1024,
  parameter int DIV_BIT = 10,
  parameter int ADD_DW  = 32
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   clk_en,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*16-1:0]      indata,
  output logic [NCH-1:0]         gnt,
  input  logic [NCH-1:0]         clr,
  output logic                   out_valid,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic signed [15:0]     AVR,
  output logic signed [15:0]     AC_data,
  output logic                   settled,
  output logic                   busy
);
  localparam int CHW = $clog2(NCH);
  localparam int PW  = $clog2(WIDTH);
  localparam int AW  = hist_aw(NCH, WIDTH);

`ifdef MOV_AVR_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef struct packed {
    logic           valid;
    logic [CHW-1:0] ch;
    sample_t        sample;
    logic [AW-1:0]  addr;
  } stage_t;

  logic [CHW-1:0]           rr_q, rr_d;
  logic [CHW-1:0]           gch;
  logic                     gany;
  logic [CHW:0]             idx;
  stage_t                   s1_q, s1_d;
  logic signed [ADD_DW-1:0] acc_q  [NCH];
  logic [PW-1:0]            wptr_q [NCH];
  logic [PW:0]              fill_q [NCH];
  sample_t                  ram_rd;

  logic                     out_vld_q;
  logic [CHW-1:0]           out_ch_q;
  sample_t                  avr_q, ac_q;
  logic                     settled_q;

  // Arbiter: first eligible channel at or after rr_q; a channel being cleared is never eligible.
  always_comb begin
    gany = 1'b0;
    gch  = '0;
    idx  = '0;
    gnt  = '0;
    if (clk_en && sys_rst_n) begin
      if (PRIO0 && req[0] && !clr[0]) begin
        gany = 1'b1;
      end
      for (int k = 0; k < NCH; k++) begin
        idx = {1'b0, rr_q} + (CHW+1)'(k);
        if (idx >= (CHW+1)'(NCH)) begin
          idx = idx - (CHW+1)'(NCH);
        end
        if (!gany && req[idx[CHW-1:0]] && !clr[idx[CHW-1:0]] &&
            !(PRIO0 && idx[CHW-1:0] == '0)) begin
          gany = 1'b1;
          gch  = idx[CHW-1:0];
        end
      end
    end
    if (gany) begin
      gnt[gch] = 1'b1;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gany && !(PRIO0 && gch == '0)) begin
      rr_d = (gch == CHW'(NCH - 1)) ? '0 : gch + CHW'(1);
    end
    s1_d.valid  = gany;
    s1_d.ch     = gch;
    s1_d.sample = indata[{gch, 4'b0000} +: 16];
    s1_d.addr   = {gch, wptr_q[gch]};
  end

  // S0 reads the slot about to be overwritten; S1 writes the new sample into it one cycle later.
  mov_avr_hist_ram #(.AW(AW)) u_hist (
    .clk_i     (sys_clk),
    .wr_en_i   (clk_en && s1_q.valid),
    .wr_addr_i (s1_q.addr),
    .wr_dat_i  (s1_q.sample),
    .rd_en_i   (gany),
    .rd_addr_i (s1_d.addr),
    .rd_dat_o  (ram_rd)
  );

  logic [PW:0]              fill_cur, fill_new;
  logic signed [ADD_DW-1:0] old_ext, smp_ext, acc_new;
  sample_t                  avr_new, ac_new;

  // Until a channel has a full window, the evicted sample is treated as zero.
  always_comb begin
    fill_cur = fill_q[s1_q.ch];
    old_ext  = (fill_cur < (PW+1)'(WIDTH)) ? '0
             : {{(ADD_DW-SAMPLE_W){ram_rd[SAMPLE_W-1]}}, ram_rd};
    smp_ext  = {{(ADD_DW-SAMPLE_W){s1_q.sample[SAMPLE_W-1]}}, s1_q.sample};
    acc_new  = acc_q[s1_q.ch] - old_ext + smp_ext;
    fill_new = (fill_cur == (PW+1)'(WIDTH)) ? fill_cur : fill_cur + (PW+1)'(1);
    avr_new  = acc_new[DIV_BIT+15:DIV_BIT];
    ac_new   = s1_q.sample - avr_new;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_q      <= '0;
      s1_q      <= '0;
      out_vld_q <= 1'b0;
      out_ch_q  <= '0;
      avr_q     <= '0;
      ac_q      <= '0;
      settled_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i]  <= '0;
        wptr_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      if (clk_en) begin
        rr_q      <= rr_d;
        s1_q      <= s1_d;
        out_vld_q <= s1_q.valid;
        if (gany) begin
          wptr_q[gch] <= wptr_q[gch] + PW'(1);
        end
        if (s1_q.valid) begin
          acc_q[s1_q.ch]  <= acc_new;
          fill_q[s1_q.ch] <= fill_new;
          out_ch_q        <= s1_q.ch;
          avr_q           <= avr_new;
          ac_q            <= ac_new;
          settled_q       <= (fill_new == (PW+1)'(WIDTH));
        end
      end
      // A flush overrides any same-edge S1 update of that channel.
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          acc_q[i]  <= '0;
          wptr_q[i] <= '0;
          fill_q[i] <= '0;
        end
      end
    end
  end

  assign out_valid = out_vld_q;
  assign out_ch    = out_ch_q;
  assign AVR       = avr_q;
  assign AC_data   = ac_q;
  assign settled   = settled_q;
  assign busy      = s1_q.valid | out_vld_q;
endmodule
